// File: rtl/boot_pkg.sv
// Shared types and constants for the boot sequencer.
package boot_pkg;

   typedef enum logic [2:0] {
      LOAD     = 3'd0,
      SEND_ACK = 3'd1,
      WAIT_TX  = 3'd2,
      RUN      = 3'd3,
      QUIESCE  = 3'd4
   } boot_state_t;

   localparam logic [7:0] ACK_BYTE_DEF = 8'h06;
   localparam logic [7:0] NAK_BYTE_DEF = 8'h15;

endpackage

// File: rtl/boot_idle_timer.sv
// Idle-cycle counter for the boot loader. It counts while enabled and
// restarts from zero on clear. It raises tc for one cycle on the
// TIMEOUT_CYC-th consecutive idle cycle.
module boot_idle_timer #(
   parameter int TIMEOUT_CYC = 1_000_000
) (
   input  logic clk,
   input  logic arst,
   input  logic en,
   input  logic clr,
   output logic tc
);

   localparam int CW = $clog2(TIMEOUT_CYC + 1);

   logic [CW-1:0] cnt_q;

   // Count idle cycles, holding at the terminal value until cleared.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         cnt_q <= '0;
      end else if (clr) begin
         cnt_q <= '0;
      end else if (en && (cnt_q != CW'(TIMEOUT_CYC))) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign tc = en && !clr && (cnt_q == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/boot_sequencer.sv
// Boot sequencer. It owns the program-memory port and the CPU reset.
// While in LOAD it steers loader writes into memory. When loading is done
// it sends an ACK or NAK byte, then releases the CPU and hands the memory
// port to instruction fetch.
// Optional build macro BOOT_TIMEOUT_EN enables an rx-idle abort during LOAD.
module boot_sequencer
   import boot_pkg::*;
#(
   parameter int         DATA_W      = 32,
   parameter int         ADDR_W      = 8,
   parameter int         MEM_BYTES   = 256,
   parameter logic [7:0] ACK_BYTE    = ACK_BYTE_DEF,
   parameter logic [7:0] NAK_BYTE    = NAK_BYTE_DEF,
   parameter int         TIMEOUT_CYC = 1_000_000
) (
   input  logic              clk,
   input  logic              arst,
   input  logic              reload_req,
   input  logic              rx_byte_vld,
   input  logic              ld_we,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              ld_done,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic              tx_done,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              cpu_rst,
   output logic              loader_en,
   output logic              tx_start,
   output logic [7:0]        tx_data,
   output logic [ADDR_W-1:0] inst_count,
   output logic              err
);

   boot_state_t       state_q, state_d;
   logic [ADDR_W-1:0] inst_count_q;
   logic              err_q;
   logic [7:0]        tx_data_q;
   logic              cpu_rst_q;
   logic              wr_ok;
   logic              wr_bad;
   logic              timeout_tc;

   // A full word must fit, so the last legal byte address is MEM_BYTES-4.
   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      return (int'(a) <= (MEM_BYTES - 4));
   endfunction

   // The instruction counter saturates instead of wrapping.
   function automatic logic [ADDR_W-1:0] sat_inc(input logic [ADDR_W-1:0] c);
      return (c == '1) ? c : c + 1'b1;
   endfunction

`ifdef BOOT_TIMEOUT_EN
   logic armed_q;

   // Arm the idle watchdog on the first received byte of a load.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         armed_q <= 1'b0;
      end else if (state_q != LOAD) begin
         armed_q <= 1'b0;
      end else if (rx_byte_vld) begin
         armed_q <= 1'b1;
      end
   end

   boot_idle_timer #(
      .TIMEOUT_CYC (TIMEOUT_CYC)
   ) u_idle_timer (
      .clk  (clk),
      .arst (arst),
      .en   (armed_q),
      .clr  (rx_byte_vld || (state_q != LOAD)),
      .tc   (timeout_tc)
   );
`else
   localparam int unused_timeout_cyc = TIMEOUT_CYC;
   logic unused_rx_byte_vld;
   assign unused_rx_byte_vld = rx_byte_vld;
   assign timeout_tc         = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q <= LOAD;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic, memory-port steering and TX strobe.
   always_comb begin
      state_d   = state_q;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      loader_en = 1'b0;
      tx_start  = 1'b0;
      tx_data   = tx_data_q;
      wr_ok     = 1'b0;
      wr_bad    = 1'b0;
      case (state_q)
         LOAD: begin
            loader_en = 1'b1;
            mem_addr  = ld_addr;
            mem_wdata = ld_data;
            wr_ok     = ld_we && in_range(ld_addr);
            wr_bad    = ld_we && !in_range(ld_addr);
            mem_we    = wr_ok;
            if (timeout_tc || ld_done) begin
               state_d = SEND_ACK;
            end
         end
         SEND_ACK: begin
            tx_start = 1'b1;
            tx_data  = err_q ? NAK_BYTE : ACK_BYTE;
            state_d  = WAIT_TX;
         end
         WAIT_TX: begin
            if (tx_done) begin
               state_d = err_q ? LOAD : RUN;
            end
         end
         RUN: begin
            mem_addr = cpu_addr;
            if (reload_req) begin
               state_d = QUIESCE;
            end
         end
         QUIESCE: begin
            state_d = LOAD;
         end
         default: begin
            state_d = LOAD;
         end
      endcase
   end

   // Load bookkeeping, the held TX byte and the registered CPU reset.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         inst_count_q <= '0;
         err_q        <= 1'b0;
         tx_data_q    <= 8'h00;
         cpu_rst_q    <= 1'b1;
      end else begin
         cpu_rst_q <= (state_d != RUN);
         if (state_q == SEND_ACK) begin
            tx_data_q <= tx_data;
         end
         if (wr_ok) begin
            inst_count_q <= sat_inc(inst_count_q);
         end
         if (wr_bad || timeout_tc) begin
            err_q <= 1'b1;
         end
         if ((state_q == WAIT_TX) && tx_done && err_q) begin
            inst_count_q <= '0;
         end
         if (state_q == QUIESCE) begin
            inst_count_q <= '0;
            err_q        <= 1'b0;
         end
      end
   end

   assign cpu_rst    = cpu_rst_q;
   assign inst_count = inst_count_q;
   assign err        = err_q;

endmodule

// File: tb/tb_boot_sequencer.sv
// Directed testbench for boot_sequencer. Build with BOOT_TIMEOUT_EN to
// also exercise the idle-timeout abort (DUT built with TIMEOUT_CYC=100).
module tb_boot_sequencer;

   logic        clk = 1'b0;
   logic        arst;
   logic        reload_req, rx_byte_vld, ld_we, ld_done, tx_done;
   logic [7:0]  ld_addr, cpu_addr;
   logic [31:0] ld_data;
   logic        mem_we, cpu_rst, loader_en, tx_start, err;
   logic [7:0]  mem_addr, tx_data, inst_count;
   logic [31:0] mem_wdata;
   int          total = 0;
   int          bad   = 0;

   always #5 clk = ~clk;

   boot_sequencer #(
      .DATA_W      (32),
      .ADDR_W      (8),
      .MEM_BYTES   (256),
      .ACK_BYTE    (8'h06),
      .NAK_BYTE    (8'h15),
      .TIMEOUT_CYC (100)
   ) dut (
      .clk         (clk),
      .arst        (arst),
      .reload_req  (reload_req),
      .rx_byte_vld (rx_byte_vld),
      .ld_we       (ld_we),
      .ld_addr     (ld_addr),
      .ld_data     (ld_data),
      .ld_done     (ld_done),
      .cpu_addr    (cpu_addr),
      .tx_done     (tx_done),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .cpu_rst     (cpu_rst),
      .loader_en   (loader_en),
      .tx_start    (tx_start),
      .tx_data     (tx_data),
      .inst_count  (inst_count),
      .err         (err)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      reload_req  = 1'b0;
      rx_byte_vld = 1'b0;
      ld_we       = 1'b0;
      ld_done     = 1'b0;
      tx_done     = 1'b0;
      ld_addr     = 8'h00;
      ld_data     = 32'h0;
      cpu_addr    = 8'h00;
   endtask

   task automatic test_reset();
      arst = 1'b1;
      idle_inputs();
      tick();
      tick();
      total++;
      if ({cpu_rst, loader_en, mem_we, tx_start, err} !== 5'b11000) begin
         bad++;
         $display("FAIL reset_ctrl: got %b want 11000", {cpu_rst, loader_en, mem_we, tx_start, err});
      end
      total++;
      if ({tx_data, inst_count} !== 16'h0000) begin
         bad++;
         $display("FAIL reset_regs: got %h want 0000", {tx_data, inst_count});
      end
      arst = 1'b0;
      tick();
   endtask

   task automatic test_load();
      int starts;
      ld_we = 1'b1; ld_addr = 8'h00; ld_data = 32'h00500093;
      #1;
      total++;
      if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 8'h00, 32'h00500093}) begin
         bad++;
         $display("FAIL load_wr0: got %b %h %h want 1 00 00500093", mem_we, mem_addr, mem_wdata);
      end
      tick();
      ld_addr = 8'h04; ld_data = 32'h00100113;
      #1;
      total++;
      if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 8'h04, 32'h00100113}) begin
         bad++;
         $display("FAIL load_wr1: got %b %h %h want 1 04 00100113", mem_we, mem_addr, mem_wdata);
      end
      tick();
      ld_we = 1'b0; ld_done = 1'b1;
      tick();
      ld_done = 1'b0;
      #1;
      total++;
      if ({tx_start, tx_data, inst_count, loader_en, cpu_rst} !== {1'b1, 8'h06, 8'd2, 1'b0, 1'b1}) begin
         bad++;
         $display("FAIL load_ack: got start=%b data=%h cnt=%0d len=%b rst=%b want 1 06 2 0 1",
                  tx_start, tx_data, inst_count, loader_en, cpu_rst);
      end
      starts = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (tx_start) starts++;
      end
      total++;
      if (starts !== 0 || tx_data !== 8'h06) begin
         bad++;
         $display("FAIL ack_single: got extra_starts=%0d data=%h want 0 06", starts, tx_data);
      end
      total++;
      if (cpu_rst !== 1'b1) begin
         bad++;
         $display("FAIL wait_tx_rst: got %b want 1", cpu_rst);
      end
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      #1;
      total++;
      if ({cpu_rst, mem_we, loader_en} !== 3'b000) begin
         bad++;
         $display("FAIL run_entry: got rst/we/len=%b want 000", {cpu_rst, mem_we, loader_en});
      end
   endtask

   task automatic test_run_fetch();
      cpu_addr = 8'h04;
      ld_we = 1'b1; ld_addr = 8'h08; ld_data = 32'hCAFEF00D;
      #1;
      total++;
      if ({mem_addr, mem_we, mem_wdata} !== {8'h04, 1'b0, 32'h0}) begin
         bad++;
         $display("FAIL run_fetch: got %h %b %h want 04 0 00000000", mem_addr, mem_we, mem_wdata);
      end
      tick();
      ld_we = 1'b0; ld_done = 1'b1;
      tick();
      ld_done = 1'b0;
      tick();
      total++;
      if ({inst_count, cpu_rst, tx_start, loader_en} !== {8'd2, 3'b000}) begin
         bad++;
         $display("FAIL run_ignore: got cnt=%0d rst=%b start=%b len=%b want 2 0 0 0",
                  inst_count, cpu_rst, tx_start, loader_en);
      end
   endtask

   task automatic test_reload();
      reload_req = 1'b1;
      tick();
      reload_req = 1'b0;
      #1;
      total++;
      if ({cpu_rst, mem_we, loader_en} !== 3'b100) begin
         bad++;
         $display("FAIL quiesce: got rst/we/len=%b want 100", {cpu_rst, mem_we, loader_en});
      end
      tick();
      total++;
      if ({loader_en, cpu_rst, err, inst_count} !== {3'b110, 8'd0}) begin
         bad++;
         $display("FAIL reload_load: got len=%b rst=%b err=%b cnt=%0d want 1 1 0 0",
                  loader_en, cpu_rst, err, inst_count);
      end
   endtask

   task automatic test_same_cycle();
      ld_we = 1'b1; ld_done = 1'b1; ld_addr = 8'h10; ld_data = 32'hDEADBEEF;
      #1;
      total++;
      if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 8'h10, 32'hDEADBEEF}) begin
         bad++;
         $display("FAIL same_wr: got %b %h %h want 1 10 deadbeef", mem_we, mem_addr, mem_wdata);
      end
      tick();
      ld_we = 1'b0; ld_done = 1'b0;
      #1;
      total++;
      if ({inst_count, tx_start, tx_data} !== {8'd1, 1'b1, 8'h06}) begin
         bad++;
         $display("FAIL same_ack: got cnt=%0d start=%b data=%h want 1 1 06", inst_count, tx_start, tx_data);
      end
      tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      reload_req = 1'b1;
      tick();
      reload_req = 1'b0;
      tick();
      total++;
      if ({loader_en, inst_count} !== {1'b1, 8'd0}) begin
         bad++;
         $display("FAIL same_reload: got len=%b cnt=%0d want 1 0", loader_en, inst_count);
      end
   endtask

   task automatic test_out_of_range();
      ld_we = 1'b1; ld_addr = 8'hFC; ld_data = 32'h11111111;
      #1;
      total++;
      if (mem_we !== 1'b1) begin
         bad++;
         $display("FAIL oor_edge_ok: got mem_we=%b want 1", mem_we);
      end
      tick();
      ld_addr = 8'hFE;
      #1;
      total++;
      if (mem_we !== 1'b0) begin
         bad++;
         $display("FAIL oor_block: got mem_we=%b want 0", mem_we);
      end
      tick();
      ld_we = 1'b0;
      #1;
      total++;
      if ({err, inst_count} !== {1'b1, 8'd1}) begin
         bad++;
         $display("FAIL oor_err: got err=%b cnt=%0d want 1 1", err, inst_count);
      end
      ld_done = 1'b1;
      tick();
      ld_done = 1'b0;
      #1;
      total++;
      if ({tx_start, tx_data} !== {1'b1, 8'h15}) begin
         bad++;
         $display("FAIL oor_nak: got start=%b data=%h want 1 15", tx_start, tx_data);
      end
      tick();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
      #1;
      total++;
      if ({loader_en, cpu_rst, err, inst_count} !== {3'b111, 8'd0}) begin
         bad++;
         $display("FAIL oor_reload: got len=%b rst=%b err=%b cnt=%0d want 1 1 1 0",
                  loader_en, cpu_rst, err, inst_count);
      end
   endtask

   task automatic test_arst_mid_load();
      ld_we = 1'b1; ld_addr = 8'h20; ld_data = 32'h12345678;
      tick();
      ld_we = 1'b0;
      #3;
      arst = 1'b1;
      #1;
      total++;
      if ({cpu_rst, loader_en, mem_we, tx_start, err, tx_data, inst_count} !== {5'b11000, 16'h1500 & 16'h0000}) begin
         bad++;
         $display("FAIL arst_mid: got rst=%b len=%b we=%b start=%b err=%b data=%h cnt=%0d want 1 1 0 0 0 00 0",
                  cpu_rst, loader_en, mem_we, tx_start, err, tx_data, inst_count);
      end
      tick();
      arst = 1'b0;
      tick();
   endtask

`ifdef BOOT_TIMEOUT_EN
   task automatic test_timeout();
      rx_byte_vld = 1'b1;
      tick();
      rx_byte_vld = 1'b0;
      for (int i = 0; i < 99; i++) tick();
      total++;
      if ({loader_en, err} !== 2'b10) begin
         bad++;
         $display("FAIL timeout_early: got len=%b err=%b want 1 0", loader_en, err);
      end
      tick();
      total++;
      if ({err, tx_start, tx_data} !== {2'b11, 8'h15}) begin
         bad++;
         $display("FAIL timeout_nak: got err=%b start=%b data=%h want 1 1 15", err, tx_start, tx_data);
      end
      #3;
      arst = 1'b1;
      #1;
      total++;
      if ({cpu_rst, loader_en, tx_start, err, tx_data, inst_count} !== {4'b1100, 16'h0000}) begin
         bad++;
         $display("FAIL timeout_arst: got rst=%b len=%b start=%b err=%b data=%h cnt=%0d want 1 1 0 0 00 0",
                  cpu_rst, loader_en, tx_start, err, tx_data, inst_count);
      end
      tick();
      arst = 1'b0;
      tick();
   endtask
`endif

   initial begin
      test_reset();
      test_load();
      test_run_fetch();
      test_reload();
      test_same_cycle();
      test_out_of_range();
      test_arst_mid_load();
`ifdef BOOT_TIMEOUT_EN
      test_timeout();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
